// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: steps LOAD/SHR/SHL/NOP commands through the USR.
// Optional build macro USR_SEQ_CTRL_ROTATE_EN: shift serial inputs come from usr_z, so the register rotates.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       usr_sel,
  output logic             usr_sl_r,
  output logic             usr_sl_l,
  output logic [WIDTH-1:0] usr_pi,
  input  logic [WIDTH-1:0] usr_z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_fill;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             w_accept;
  logic             w_fill_r, w_fill_l;

  assign w_accept = cmd_valid && (r_state == S_IDLE);

`ifdef USR_SEQ_CTRL_ROTATE_EN
  // Feed the bit falling off one end back into the other end.
  assign w_fill_r = usr_z[0];
  assign w_fill_l = usr_z[WIDTH-1];
`else
  assign w_fill_r = r_fill;
  assign w_fill_l = r_fill;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_NOP;
      r_data   <= '0;
      r_fill   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      if (r_state == S_DONE) r_result <= usr_z;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_fill <= cmd_fill;
        r_cnt  <= cmd_count;
      end else if (r_state == S_SHIFT) begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    usr_sel  = 2'b00;
    usr_sl_r = 1'b0;
    usr_sl_l = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD:        w_next = S_LOAD;
            OP_SHR, OP_SHL: w_next = (cmd_count != '0) ? S_SHIFT : S_DONE;
            default:        w_next = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        usr_sel = 2'b11;
        w_next  = S_DONE;
      end
      S_SHIFT: begin
        if (r_op == OP_SHR) begin
          usr_sel  = 2'b01;
          usr_sl_r = w_fill_r;
        end else begin
          usr_sel  = 2'b10;
          usr_sl_l = w_fill_l;
        end
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign usr_pi    = r_data;
  assign done      = r_done;
  assign result    = r_result;

endmodule
